// File: rtl/branch_resolve_if.sv
// Valid/ready bundle between decode/regread (master) and the branch resolve unit (slave).
// Carries the operand request on the input side and the resolved branch on the output side.
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      branch_op;
  logic [XLEN-1:0] data_in1;
  logic [XLEN-1:0] data_in2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic            branch_out;
  logic [XLEN-1:0] target;
  logic            mispredict;

  modport master (
    output in_valid, branch_op, data_in1, data_in2, pc, imm, pred_taken, out_ready,
    input  in_ready, out_valid, branch_out, target, mispredict
  );

  modport slave (
    input  in_valid, branch_op, data_in1, data_in2, pc, imm, pred_taken, out_ready,
    output in_ready, out_valid, branch_out, target, mispredict
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Pipelined RV32 conditional-branch resolution: condition, target, mispredict flag and
// saturating branch/mispredict statistics, with valid/ready on both sides and a flush.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             cnt_clr_i,
  branch_resolve_if.slave  br_if,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  function automatic logic br_taken(input logic [2:0]      op,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLT:  return sa < sb;
      OP_BGE:  return sa >= sb;
      OP_BLTU: return a < b;
      OP_BGEU: return a >= b;
      // 3'b010 / 3'b011 are not branches and never resolve taken
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic            in_ready_c;
  logic            accept;
  logic            s_vld;
  logic            s_taken;
  logic            s_pred;
  logic [XLEN-1:0] s_pc;
  logic [XLEN-1:0] s_imm;

  logic            vld_p1_q;
  logic            taken_p1_q;
  logic            mis_p1_q;
  logic [XLEN-1:0] tgt_p1_q;
  logic            adv_p1;

  logic             retire;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  assign adv_p1 = !vld_p1_q || br_if.out_ready;
  assign accept = br_if.in_valid && in_ready_c;

  generate
    if (LATENCY == 2) begin : g_lat2
      logic            vld_p0_q;
      logic            taken_p0_q;
      logic            pred_p0_q;
      logic [XLEN-1:0] pc_p0_q;
      logic [XLEN-1:0] imm_p0_q;

      // ---- stage p0: condition evaluation ----
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vld_p0_q <= 1'b0;
        end else if (flush_i) begin
          vld_p0_q <= 1'b0;
        end else if (!vld_p0_q || adv_p1) begin
          vld_p0_q <= accept;
        end
      end

      always_ff @(posedge clk_i) begin
        if (accept) begin
          taken_p0_q <= br_taken(br_if.branch_op, br_if.data_in1, br_if.data_in2);
          pred_p0_q  <= br_if.pred_taken;
          pc_p0_q    <= br_if.pc;
          imm_p0_q   <= br_if.imm;
        end
      end

      assign in_ready_c = !flush_i && (!vld_p0_q || adv_p1);
      assign s_vld      = vld_p0_q;
      assign s_taken    = taken_p0_q;
      assign s_pred     = pred_p0_q;
      assign s_pc       = pc_p0_q;
      assign s_imm      = imm_p0_q;
    end else begin : g_lat1
      assign in_ready_c = !flush_i && adv_p1;
      assign s_vld      = accept;
      assign s_taken    = br_taken(br_if.branch_op, br_if.data_in1, br_if.data_in2);
      assign s_pred     = br_if.pred_taken;
      assign s_pc       = br_if.pc;
      assign s_imm      = br_if.imm;
    end
  endgenerate

  // ---- stage p1: target / mispredict, output register ----
  // Data only loads on a real advance, so a stalled result stays stable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1_q   <= 1'b0;
      taken_p1_q <= 1'b0;
      tgt_p1_q   <= '0;
      mis_p1_q   <= 1'b0;
    end else begin
      if (flush_i) begin
        vld_p1_q <= 1'b0;
      end else if (adv_p1) begin
        vld_p1_q <= s_vld;
      end
      if (adv_p1 && s_vld && !flush_i) begin
        taken_p1_q <= s_taken;
        tgt_p1_q   <= s_taken ? (s_pc + s_imm) : (s_pc + XLEN'(4));
        mis_p1_q   <= s_taken != s_pred;
      end
    end
  end

  // Flush beats out_ready: a result leaving in the flush cycle is not counted.
  assign retire = vld_p1_q && br_if.out_ready && !flush_i;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (cnt_clr_i) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (retire) begin
      branch_cnt_d = sat_inc(branch_cnt_q);
      if (mis_p1_q) mispred_cnt_d = sat_inc(mispred_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_if.in_ready   = in_ready_c;
  assign br_if.out_valid  = vld_p1_q;
  assign br_if.branch_out = taken_p1_q;
  assign br_if.target     = tgt_p1_q;
  assign br_if.mispredict = mis_p1_q && vld_p1_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispred_cnt_o    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a LATENCY=2/CNT_W=4 unit (u2) and a LATENCY=1/CNT_W=16 unit (u1)
// fed from shared stimulus, checked against a spec-level model of branch resolution.
module tb_branch_resolve_unit;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
  } vec_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] tgt;
    logic        mis;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        cnt_clr;
  logic        u1_en;
  logic [15:0] bcnt1, mcnt1;
  logic [3:0]  bcnt2, mcnt2;

  int n_pass = 0;
  int n_total = 0;

  branch_resolve_if #(.XLEN(32)) bi1 ();
  branch_resolve_if #(.XLEN(32)) bi2 ();

  assign bi1.in_valid   = bi2.in_valid & u1_en;
  assign bi1.branch_op  = bi2.branch_op;
  assign bi1.data_in1   = bi2.data_in1;
  assign bi1.data_in2   = bi2.data_in2;
  assign bi1.pc         = bi2.pc;
  assign bi1.imm        = bi2.imm;
  assign bi1.pred_taken = bi2.pred_taken;
  assign bi1.out_ready  = bi2.out_ready;

  branch_resolve_unit #(.XLEN(32), .LATENCY(1), .CNT_W(16)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .cnt_clr_i(cnt_clr),
    .br_if(bi1.slave), .branch_cnt_o(bcnt1), .mispred_cnt_o(mcnt1)
  );

  branch_resolve_unit #(.XLEN(32), .LATENCY(2), .CNT_W(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .cnt_clr_i(cnt_clr),
    .br_if(bi2.slave), .branch_cnt_o(bcnt2), .mispred_cnt_o(mcnt2)
  );

  // Reference: condition from the RV rules, target via 64-bit sum truncated to 32 bits.
  function automatic res_t model(input vec_t v);
    res_t        r;
    logic [63:0] sum;
    case (v.op)
      3'b000:  r.taken = (v.a == v.b);
      3'b001:  r.taken = (v.a != v.b);
      3'b100:  r.taken = ((v.a ^ 32'h8000_0000) <  (v.b ^ 32'h8000_0000));
      3'b101:  r.taken = ((v.a ^ 32'h8000_0000) >= (v.b ^ 32'h8000_0000));
      3'b110:  r.taken = (v.a < v.b);
      3'b111:  r.taken = (v.a >= v.b);
      default: r.taken = 1'b0;
    endcase
    sum   = {32'd0, v.pc} + (r.taken ? {{32{v.imm[31]}}, v.imm} : 64'd4);
    r.tgt = sum[31:0];
    r.mis = r.taken ^ v.pred;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t        v;
    logic [12:0] r;
    v.op = 3'($urandom_range(0, 7));
    v.a  = $urandom;
    case ($urandom_range(0, 3))
      0:       v.b = v.a;
      1:       v.b = v.a ^ 32'h8000_0000;
      default: v.b = $urandom;
    endcase
    v.pc   = $urandom & 32'hFFFF_FFFC;
    r      = 13'($urandom);
    v.imm  = ($urandom_range(0, 3) == 0) ? $urandom : {{19{r[12]}}, r[12:1], 1'b0};
    v.pred = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic put(input vec_t v, input logic vld);
    bi2.in_valid   = vld;
    bi2.branch_op  = v.op;
    bi2.data_in1   = v.a;
    bi2.data_in2   = v.b;
    bi2.pc         = v.pc;
    bi2.imm        = v.imm;
    bi2.pred_taken = v.pred;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; cnt_clr = 1'b1; put('0, 1'b0);
    @(posedge clk); #1; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0; u1_en = 1'b1;
    bi2.out_ready = 1'b1;
    put('0, 1'b0);
    repeat (3) @(posedge clk);
    #1; #6;
    n_total++;
    if ({bi2.out_valid, bi2.branch_out, bi2.target, bi2.mispredict} !== 35'd0)
      $display("FAIL reset_u2_out got=%h exp=0",
               {bi2.out_valid, bi2.branch_out, bi2.target, bi2.mispredict});
    else n_pass++;
    n_total++;
    if ({bi1.out_valid, bi1.branch_out, bi1.target, bi1.mispredict} !== 35'd0)
      $display("FAIL reset_u1_out got=%h exp=0",
               {bi1.out_valid, bi1.branch_out, bi1.target, bi1.mispredict});
    else n_pass++;
    n_total++;
    if ({bcnt2, mcnt2, bcnt1, mcnt1} !== 40'd0)
      $display("FAIL reset_cnt got=%h exp=0", {bcnt2, mcnt2, bcnt1, mcnt1});
    else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1; #6;
    n_total++;
    if ({bi2.in_ready, bi1.in_ready} !== 2'b11)
      $display("FAIL reset_in_ready got=%b exp=11", {bi2.in_ready, bi1.in_ready});
    else n_pass++;
  endtask

  task automatic test_directed();
    vec_t dv[8];
    res_t de[8];
    int   at;
    dv[0] = {3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'hFFFF_FFF8, 1'b0}; de[0] = {1'b1, 32'hF8, 1'b1};
    dv[1] = {3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'hFFFF_FFF8, 1'b0}; de[1] = {1'b0, 32'h104, 1'b0};
    dv[2] = {3'b000, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 1'b1};           de[2] = {1'b1, 32'h4, 1'b0};
    dv[3] = {3'b001, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 1'b0};           de[3] = {1'b0, 32'h0, 1'b0};
    dv[4] = {3'b010, 32'd7, 32'd7, 32'h200, 32'h10, 1'b1};                de[4] = {1'b0, 32'h204, 1'b1};
    dv[5] = {3'b011, 32'd7, 32'd9, 32'h300, 32'h10, 1'b0};                de[5] = {1'b0, 32'h304, 1'b0};
    dv[6] = {3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1000, 32'hFFFF_F000, 1'b1};
    de[6] = {1'b0, 32'h1004, 1'b1};
    dv[7] = {3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1000, 32'hFFFF_F000, 1'b1};
    de[7] = {1'b1, 32'h0, 1'b0};
    bi2.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; put(dv[i], 1'b1);
      at = -1;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1; put(dv[i], 1'b0); #6;
        if (bi2.out_valid) begin at = c; break; end
      end
      n_total++;
      if (at != 1) $display("FAIL directed%0d_latency got=%0d exp=1", i, at);
      else n_pass++;
      if (at >= 0) begin
        n_total++;
        if ({bi2.branch_out, bi2.target, bi2.mispredict} !== de[i])
          $display("FAIL directed%0d_result got=%h exp=%h", i,
                   {bi2.branch_out, bi2.target, bi2.mispredict}, de[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t bb[8];
    int   nmis = 0;
    logic ev;
    for (int i = 0; i < 8; i++) begin
      bb[i] = rand_vec();
      nmis += int'(model(bb[i]).mis);
    end
    u1_en = 1'b1; bi2.out_ready = 1'b1;
    pulse_clr();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      put(bb[c < 8 ? c : 0], c < 8); #6;
      if (c < 8) begin
        n_total++;
        if (bi2.in_ready !== 1'b1) $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, bi2.in_ready);
        else n_pass++;
      end
      ev = (c >= 2 && c < 10);
      n_total++;
      if (bi2.out_valid !== ev) $display("FAIL b2b_u2_valid c=%0d got=%b exp=%b", c, bi2.out_valid, ev);
      else n_pass++;
      if (ev) begin
        n_total++;
        if ({bi2.branch_out, bi2.target, bi2.mispredict} !== model(bb[c-2]))
          $display("FAIL b2b_u2_data c=%0d got=%h exp=%h", c,
                   {bi2.branch_out, bi2.target, bi2.mispredict}, model(bb[c-2]));
        else n_pass++;
      end
      ev = (c >= 1 && c < 9);
      n_total++;
      if (bi1.out_valid !== ev) $display("FAIL b2b_u1_valid c=%0d got=%b exp=%b", c, bi1.out_valid, ev);
      else n_pass++;
      if (ev) begin
        n_total++;
        if ({bi1.branch_out, bi1.target, bi1.mispredict} !== model(bb[c-1]))
          $display("FAIL b2b_u1_data c=%0d got=%h exp=%h", c,
                   {bi1.branch_out, bi1.target, bi1.mispredict}, model(bb[c-1]));
        else n_pass++;
      end
    end
    n_total++;
    if ({bcnt2, mcnt2} !== {4'd8, 4'(nmis)})
      $display("FAIL b2b_u2_cnt got=%h exp=%h", {bcnt2, mcnt2}, {4'd8, 4'(nmis)});
    else n_pass++;
    n_total++;
    if ({bcnt1, mcnt1} !== {16'd8, 16'(nmis)})
      $display("FAIL b2b_u1_cnt got=%h exp=%h", {bcnt1, mcnt1}, {16'd8, 16'(nmis)});
    else n_pass++;
  endtask

  task automatic test_hold();
    vec_t hv[6];
    res_t q[$];
    res_t snap;
    res_t exp_r;
    int   idx = 0, got = 0, nmis = 0;
    for (int i = 0; i < 6; i++) begin
      hv[i] = rand_vec();
      nmis += int'(model(hv[i]).mis);
    end
    u1_en = 1'b0;
    pulse_clr();
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bi2.out_ready = (c >= 7);
      put(hv[idx < 6 ? idx : 0], idx < 6); #6;
      if (c == 2) snap = {bi2.branch_out, bi2.target, bi2.mispredict};
      if (c >= 2 && c < 7) begin
        n_total++;
        if ({bi2.in_ready, bi2.out_valid} !== 2'b01)
          $display("FAIL hold_handshake c=%0d got=%b exp=01", c, {bi2.in_ready, bi2.out_valid});
        else n_pass++;
      end
      if (c >= 3 && c < 7) begin
        n_total++;
        if ({bi2.branch_out, bi2.target, bi2.mispredict} !== snap)
          $display("FAIL hold_stable c=%0d got=%h exp=%h", c,
                   {bi2.branch_out, bi2.target, bi2.mispredict}, snap);
        else n_pass++;
      end
      if (bi2.out_valid && bi2.out_ready) begin
        exp_r = (q.size() > 0) ? q.pop_front() : '0;
        n_total++;
        if ({bi2.branch_out, bi2.target, bi2.mispredict} !== exp_r)
          $display("FAIL hold_order beat=%0d got=%h exp=%h", got,
                   {bi2.branch_out, bi2.target, bi2.mispredict}, exp_r);
        else n_pass++;
        got++;
      end
      if (bi2.in_valid && bi2.in_ready) begin
        q.push_back(model(hv[idx]));
        idx++;
      end
    end
    @(posedge clk); #1; put('0, 1'b0); #6;
    n_total++;
    if (got != 6) $display("FAIL hold_beats got=%0d exp=6", got);
    else n_pass++;
    n_total++;
    if ({bcnt2, mcnt2} !== {4'd6, 4'(nmis)})
      $display("FAIL hold_cnt got=%h exp=%h", {bcnt2, mcnt2}, {4'd6, 4'(nmis)});
    else n_pass++;
  endtask

  task automatic test_flush();
    vec_t f[3];
    for (int i = 0; i < 3; i++) f[i] = rand_vec();
    u1_en = 1'b1; bi2.out_ready = 1'b1;
    pulse_clr();
    put(f[0], 1'b1);
    @(posedge clk); #1; put(f[1], 1'b1);
    @(posedge clk); #1; put(f[2], 1'b1); flush = 1'b1; #6;
    n_total++;
    if ({bi2.in_ready, bi1.in_ready, bi2.out_valid} !== 3'b001)
      $display("FAIL flush_cycle got=%b exp=001", {bi2.in_ready, bi1.in_ready, bi2.out_valid});
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1; flush = 1'b0; put('0, 1'b0); #6;
      n_total++;
      if ({bi2.out_valid, bi1.out_valid} !== 2'b00)
        $display("FAIL flush_after c=%0d got=%b exp=00", c, {bi2.out_valid, bi1.out_valid});
      else n_pass++;
    end
    n_total++;
    if ({bcnt2, mcnt2} !== 8'd0) $display("FAIL flush_u2_cnt got=%h exp=00", {bcnt2, mcnt2});
    else n_pass++;
    n_total++;
    if ({bcnt1, mcnt1} !== {16'd1, 15'd0, model(f[0]).mis})
      $display("FAIL flush_u1_cnt got=%h exp=%h", {bcnt1, mcnt1}, {16'd1, 15'd0, model(f[0]).mis});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    u1_en = 1'b1; bi2.out_ready = 1'b1;
    @(posedge clk); #1; put(rand_vec(), 1'b1);
    @(posedge clk); #1; put(rand_vec(), 1'b1);
    @(posedge clk); #1; put('0, 1'b0); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #6;
      n_total++;
      if ({bi2.out_valid, bi1.out_valid} !== 2'b00)
        $display("FAIL rstmid_valid c=%0d got=%b exp=00", c, {bi2.out_valid, bi1.out_valid});
      else n_pass++;
    end
    n_total++;
    if ({bcnt2, mcnt2, bcnt1, mcnt1} !== 40'd0)
      $display("FAIL rstmid_cnt got=%h exp=0", {bcnt2, mcnt2, bcnt1, mcnt1});
    else n_pass++;
  endtask

  task automatic test_counters();
    vec_t v;
    u1_en = 1'b1; bi2.out_ready = 1'b1;
    pulse_clr();
    for (int i = 0; i < 24; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      v = rand_vec(); v.op = 3'b000; v.b = v.a; v.pred = 1'b0;
      put(v, i < 20);
    end
    #6;
    n_total++;
    if ({bcnt2, mcnt2} !== 8'hFF) $display("FAIL sat_u2_cnt got=%h exp=ff", {bcnt2, mcnt2});
    else n_pass++;
    n_total++;
    if ({bcnt1, mcnt1} !== {16'd20, 16'd20})
      $display("FAIL sat_u1_cnt got=%h exp=%h", {bcnt1, mcnt1}, {16'd20, 16'd20});
    else n_pass++;
    @(posedge clk); #1; put(v, 1'b1);
    @(posedge clk); #1; put(v, 1'b0);
    @(posedge clk); #1; cnt_clr = 1'b1; #6;
    n_total++;
    if ({bi2.out_valid, bi2.out_ready} !== 2'b11)
      $display("FAIL clr_retire_beat got=%b exp=11", {bi2.out_valid, bi2.out_ready});
    else n_pass++;
    @(posedge clk); #1; cnt_clr = 1'b0; #6;
    n_total++;
    if ({bcnt2, mcnt2, bcnt1, mcnt1} !== 40'd0)
      $display("FAIL clr_wins got=%h exp=0", {bcnt2, mcnt2, bcnt1, mcnt1});
    else n_pass++;
  endtask

  task automatic test_random();
    res_t q1[$], q2[$];
    res_t exp_r;
    vec_t v = '0;
    logic vld = 1'b0, held = 1'b0;
    int   eb1 = 0, em1 = 0, eb2 = 0, em2 = 0;
    u1_en = 1'b1;
    pulse_clr();
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (c < 490) begin
        bi2.out_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 31) == 0);
        if (!held) begin v = rand_vec(); vld = ($urandom_range(0, 2) != 0); end
      end else begin
        bi2.out_ready = 1'b1; flush = 1'b0; vld = 1'b0;
      end
      put(v, vld); #6;
      if (flush) begin
        n_total++;
        if ({bi2.in_ready, bi1.in_ready} !== 2'b00)
          $display("FAIL rnd_flush_ready c=%0d got=%b exp=00", c, {bi2.in_ready, bi1.in_ready});
        else n_pass++;
        q1.delete(); q2.delete();
      end else begin
        if (bi2.out_valid && bi2.out_ready) begin
          exp_r = (q2.size() > 0) ? q2.pop_front() : '0;
          n_total++;
          if ({bi2.branch_out, bi2.target, bi2.mispredict} !== exp_r)
            $display("FAIL rnd_u2_beat c=%0d got=%h exp=%h", c,
                     {bi2.branch_out, bi2.target, bi2.mispredict}, exp_r);
          else n_pass++;
          eb2 = (eb2 < 15) ? eb2 + 1 : 15;
          if (exp_r.mis) em2 = (em2 < 15) ? em2 + 1 : 15;
        end
        if (bi1.out_valid && bi1.out_ready) begin
          exp_r = (q1.size() > 0) ? q1.pop_front() : '0;
          n_total++;
          if ({bi1.branch_out, bi1.target, bi1.mispredict} !== exp_r)
            $display("FAIL rnd_u1_beat c=%0d got=%h exp=%h", c,
                     {bi1.branch_out, bi1.target, bi1.mispredict}, exp_r);
          else n_pass++;
          eb1++;
          if (exp_r.mis) em1++;
        end
        if (bi2.in_valid && bi2.in_ready) q2.push_back(model(v));
        if (bi1.in_valid && bi1.in_ready) q1.push_back(model(v));
      end
      held = bi2.in_valid && !bi2.in_ready;
    end
    n_total++;
    if ((q1.size() + q2.size()) != 0)
      $display("FAIL rnd_drain got=%0d/%0d exp=0/0", q1.size(), q2.size());
    else n_pass++;
    n_total++;
    if ({bcnt2, mcnt2} !== {4'(eb2), 4'(em2)})
      $display("FAIL rnd_u2_cnt got=%h exp=%h", {bcnt2, mcnt2}, {4'(eb2), 4'(em2)});
    else n_pass++;
    n_total++;
    if ({bcnt1, mcnt1} !== {16'(eb1), 16'(em1)})
      $display("FAIL rnd_u1_cnt got=%h exp=%h", {bcnt1, mcnt1}, {16'(eb1), 16'(em1)});
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_flush();
    test_reset_mid();
    test_counters();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
